// File: rtl/ids_bus_pkg.sv
// Shared bus-fabric types and limits.
//   arb_mode_e : arbitration policy selector for ids_bus_arbiter_n
//   MAX_MST    : upper bound on masters, shared by the decoder, the mux and the arbiter
package ids_bus_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  localparam int unsigned MAX_MST = 16;

endpackage

// File: rtl/ids_prio_pick.sv
// Combinational find-first-set with a wrapping start position.
// Ports:
//   vec   : request vector, NUM_MST bits
//   start : index where the search begins (must be < NUM_MST)
//   found : any bit of vec set
//   idx   : first set index at or after start, wrapping modulo NUM_MST
module ids_prio_pick #(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_MST-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // start + ofs modulo NUM_MST; both operands are below NUM_MST
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned ofs);
    int unsigned pos;
    pos = 32'(base) + ofs;
    if (pos >= NUM_MST) pos = pos - NUM_MST;
    return IDX_W'(pos);
  endfunction

  // Walk candidates in search order and keep the first hit
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (!found && vec[wrap_add(start, i)]) begin
        found = 1'b1;
        idx   = wrap_add(start, i);
      end
    end
  end

endmodule

// File: rtl/ids_bus_arbiter_n.sv
// N-master bus arbiter with registered one-hot grants.
// Fixed-priority (index 0 highest, preemptive) or round-robin with a bounded
// hold time; the current owner's lock blocks preemption and rotation.
// Ports:
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_req       : per-master level request
//   i_lock      : per-master lock, honoured only for the requesting owner
//   o_gnt       : registered one-hot grant (or zero)
//   o_gnt_idx   : index of the granted master, 0 when idle
//   o_gnt_valid : a grant is active
module ids_bus_arbiter_n
  import ids_bus_pkg::*;
#(
  parameter int unsigned  NUM_MST  = 4,
  parameter arb_mode_e    MODE     = ARB_FIXED,
  parameter int unsigned  MAX_HOLD = 16,
  localparam int unsigned IDX_W    = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_MST-1:0] i_req,
  input  logic [NUM_MST-1:0] i_lock,
  output logic [NUM_MST-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_valid
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  state_e             state_q, state_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;
  logic [NUM_MST-1:0] gnt_q, gnt_n;

  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_next;

  logic               owner_req;
  logic               owner_lock;
  logic               others_req;
  logic               hold_expired;
  logic               rr_keep;
  logic               fixed_keep;
  logic [HOLD_W-1:0]  hold_inc;

  assign pick_start = (MODE == ARB_RR) ? rr_ptr_q : '0;

  ids_prio_pick #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_pick (
    .vec   (i_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pointer position just past the candidate winner
  assign pick_next = (32'(pick_idx) == NUM_MST - 1) ? '0 : pick_idx + IDX_W'(1);

  // Owner status and retention conditions
  assign owner_req    = (state_q == ST_GRANT) && i_req[owner_q];
  assign owner_lock   = owner_req && i_lock[owner_q];
  assign others_req   = |(i_req & ~(NUM_MST'(1) << owner_q));
  assign hold_inc     = (&hold_q) ? hold_q : hold_q + HOLD_W'(1);
  // >= rather than == so an owner whose lock carried it past the limit still yields
  assign hold_expired = (MAX_HOLD != 0) && (32'(hold_q) + 32'd1 >= MAX_HOLD);
  assign rr_keep      = (MODE == ARB_RR) && owner_req && !(hold_expired && others_req);
  assign fixed_keep   = (MODE == ARB_FIXED) && owner_req && (pick_idx == owner_q);

  // Next-state and next-output decision
  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    hold_n   = hold_q;
    rr_ptr_n = rr_ptr_q;
    if (i_req == '0) begin
      state_n = ST_IDLE;
      owner_n = '0;
      hold_n  = '0;
    end else if (owner_lock || rr_keep || fixed_keep) begin
      hold_n = hold_inc;
    end else if (pick_found) begin
      state_n  = ST_GRANT;
      owner_n  = pick_idx;
      hold_n   = '0;
      rr_ptr_n = pick_next;
    end
    gnt_n = (state_n == ST_GRANT) ? (NUM_MST'(1) << owner_n) : '0;
  end

  // State, arbitration bookkeeping and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      hold_q   <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      hold_q   <= hold_n;
      rr_ptr_q <= rr_ptr_n;
      gnt_q    <= gnt_n;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_idx   = owner_q;
  assign o_gnt_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_ids_bus_arbiter_n.sv
// Directed bench for ids_bus_arbiter_n: fixed-priority, round-robin (MAX_HOLD 4
// and unlimited) and single-master instances on one clock. Expected grants are
// queued when stimulus is applied and checked just after the following edge.
module tb_ids_bus_arbiter_n;
  import ids_bus_pkg::*;

  localparam int I_FIX = 0;
  localparam int I_RR4 = 1;
  localparam int I_RR0 = 2;
  localparam int I_ONE = 3;

  typedef struct {
    int         inst;
    logic [3:0] gnt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       clk;
  logic       rst;
  logic [3:0] req_fix, lock_fix, gnt_fix;
  logic [3:0] req_rr4, lock_rr4, gnt_rr4;
  logic [3:0] req_rr0, lock_rr0, gnt_rr0;
  logic [1:0] idx_fix, idx_rr4, idx_rr0;
  logic       v_fix, v_rr4, v_rr0;
  logic [0:0] req_one, lock_one, gnt_one, idx_one;
  logic       v_one;

  ids_bus_arbiter_n #(.NUM_MST(4), .MODE(ARB_FIXED), .MAX_HOLD(16)) u_fix (
    .i_clk(clk), .i_rst(rst), .i_req(req_fix), .i_lock(lock_fix),
    .o_gnt(gnt_fix), .o_gnt_idx(idx_fix), .o_gnt_valid(v_fix));

  ids_bus_arbiter_n #(.NUM_MST(4), .MODE(ARB_RR), .MAX_HOLD(4)) u_rr4 (
    .i_clk(clk), .i_rst(rst), .i_req(req_rr4), .i_lock(lock_rr4),
    .o_gnt(gnt_rr4), .o_gnt_idx(idx_rr4), .o_gnt_valid(v_rr4));

  ids_bus_arbiter_n #(.NUM_MST(4), .MODE(ARB_RR), .MAX_HOLD(0)) u_rr0 (
    .i_clk(clk), .i_rst(rst), .i_req(req_rr0), .i_lock(lock_rr0),
    .o_gnt(gnt_rr0), .o_gnt_idx(idx_rr0), .o_gnt_valid(v_rr0));

  ids_bus_arbiter_n #(.NUM_MST(1), .MODE(ARB_RR), .MAX_HOLD(2)) u_one (
    .i_clk(clk), .i_rst(rst), .i_req(req_one), .i_lock(lock_one),
    .o_gnt(gnt_one), .o_gnt_idx(idx_one), .o_gnt_valid(v_one));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] onehot_idx(input logic [3:0] g);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction

  task automatic expect_gnt(input int inst, input logic [3:0] gnt, input string tag);
    exp_t e;
    e.inst = inst;
    e.gnt  = gnt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [3:0] og;
    logic [3:0] oi;
    logic       ov;
    logic [3:0] ei;
    logic       ev;
    case (e.inst)
      I_FIX:   begin og = gnt_fix; oi = 4'(idx_fix); ov = v_fix; end
      I_RR4:   begin og = gnt_rr4; oi = 4'(idx_rr4); ov = v_rr4; end
      I_RR0:   begin og = gnt_rr0; oi = 4'(idx_rr0); ov = v_rr0; end
      default: begin og = 4'(gnt_one); oi = 4'(idx_one); ov = v_one; end
    endcase
    ei = onehot_idx(e.gnt);
    ev = |e.gnt;
    n_assert++;
    assert (og === e.gnt) else begin
      n_fail++;
      $error("FAIL %s gnt: observed %b expected %b", e.tag, og, e.gnt);
    end
    n_assert++;
    assert (oi === ei) else begin
      n_fail++;
      $error("FAIL %s idx: observed %0d expected %0d", e.tag, oi, ei);
    end
    n_assert++;
    assert (ov === ev) else begin
      n_fail++;
      $error("FAIL %s valid: observed %b expected %b", e.tag, ov, ev);
    end
  endtask

  // Advance one edge, then compare everything queued for it
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  initial begin
    logic [3:0] e;

    // Reset wins over full requests on every instance
    rst = 1'b1;
    req_fix = 4'b1111; req_rr4 = 4'b1111; req_rr0 = 4'b1111; req_one = 1'b1;
    lock_fix = '0; lock_rr4 = '0; lock_rr0 = '0; lock_one = '0;
    for (int c = 0; c < 3; c++) begin
      expect_gnt(I_FIX, 4'b0000, "rst_fix");
      expect_gnt(I_RR4, 4'b0000, "rst_rr4");
      expect_gnt(I_RR0, 4'b0000, "rst_rr0");
      expect_gnt(I_ONE, 4'b0000, "rst_one");
      tick();
    end
    rst = 1'b0;
    expect_gnt(I_FIX, 4'b0001, "rel_fix");
    expect_gnt(I_RR4, 4'b0001, "rel_rr4");
    expect_gnt(I_RR0, 4'b0001, "rel_rr0");
    expect_gnt(I_ONE, 4'b0001, "rel_one");
    tick();

    // RR fairness, MAX_HOLD 4, all requesting: 0,0,0,0,1,1,1,1,...
    req_fix = '0; req_rr0 = '0; req_one = '0;
    for (int k = 1; k < 20; k++) begin
      e = 4'b0001 << ((k / 4) % 4);
      expect_gnt(I_RR4, e, "rr_fair");
      tick();
    end

    // RR pointer survives idle: master 2 last owner, then 0101 wraps to 0
    req_rr4 = 4'b0100; expect_gnt(I_RR4, 4'b0100, "rr_own2"); tick();
    req_rr4 = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      expect_gnt(I_RR4, 4'b0000, "rr_idle");
      tick();
    end
    req_rr4 = 4'b0101; expect_gnt(I_RR4, 4'b0001, "rr_wrap"); tick();
    for (int c = 0; c < 3; c++) begin
      expect_gnt(I_RR4, 4'b0001, "rr_hold0");
      tick();
    end
    expect_gnt(I_RR4, 4'b0100, "rr_rot2"); tick();

    // RR lock holds past MAX_HOLD; a non-requesting owner's lock is void
    lock_rr4 = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      expect_gnt(I_RR4, 4'b0100, "rr_lock");
      tick();
    end
    req_rr4 = 4'b0001; expect_gnt(I_RR4, 4'b0001, "rr_lock_drop"); tick();
    req_rr4 = 4'b0000; lock_rr4 = '0; expect_gnt(I_RR4, 4'b0000, "rr_none"); tick();

    // Fixed priority: preemption, handover, lock, non-owner lock ignored
    req_fix = 4'b1010; expect_gnt(I_FIX, 4'b0010, "fx_1010"); tick();
    req_fix = 4'b1011; expect_gnt(I_FIX, 4'b0001, "fx_preempt"); tick();
    req_fix = 4'b1000; expect_gnt(I_FIX, 4'b1000, "fx_handover"); tick();
    lock_fix = 4'b1000; expect_gnt(I_FIX, 4'b1000, "fx_lock3"); tick();
    req_fix = 4'b1001;
    for (int c = 0; c < 2; c++) begin
      expect_gnt(I_FIX, 4'b1000, "fx_lock_hold");
      tick();
    end
    lock_fix = 4'b0000; expect_gnt(I_FIX, 4'b0001, "fx_unlock"); tick();
    req_fix = 4'b0100; expect_gnt(I_FIX, 4'b0100, "fx_own2"); tick();
    req_fix = 4'b0110; lock_fix = 4'b0010; expect_gnt(I_FIX, 4'b0010, "fx_nonowner_lock"); tick();
    req_fix = 4'b0100; expect_gnt(I_FIX, 4'b0100, "fx_lock_noreq"); tick();
    req_fix = 4'b0000; lock_fix = '0; expect_gnt(I_FIX, 4'b0000, "fx_none"); tick();

    // RR unlimited hold: master 1 keeps the bus until it drops, then no bubble
    req_rr0 = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      expect_gnt(I_RR0, 4'b0010, "rr0_solo");
      tick();
    end
    req_rr0 = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      expect_gnt(I_RR0, 4'b0010, "rr0_unlimited");
      tick();
    end
    req_rr0 = 4'b1000; expect_gnt(I_RR0, 4'b1000, "rr0_handover"); tick();
    req_rr0 = 4'b0000; expect_gnt(I_RR0, 4'b0000, "rr0_none"); tick();

    // Single master: grant follows request one cycle later
    req_one = 1'b1; expect_gnt(I_ONE, 4'b0001, "one_on"); tick();
    expect_gnt(I_ONE, 4'b0001, "one_hold"); tick();
    expect_gnt(I_ONE, 4'b0001, "one_hold2"); tick();
    req_one = 1'b0; expect_gnt(I_ONE, 4'b0000, "one_off"); tick();
    req_one = 1'b1; expect_gnt(I_ONE, 4'b0001, "one_again"); tick();

    // Reset mid-grant drops grants and restarts RR search at 0
    req_fix = 4'b0100; req_rr4 = 4'b0100;
    expect_gnt(I_FIX, 4'b0100, "mid_fix_pre");
    expect_gnt(I_RR4, 4'b0100, "mid_rr4_pre");
    tick();
    rst = 1'b1; req_rr4 = 4'b1010;
    expect_gnt(I_FIX, 4'b0000, "mid_fix_rst");
    expect_gnt(I_RR4, 4'b0000, "mid_rr4_rst");
    expect_gnt(I_ONE, 4'b0000, "mid_one_rst");
    tick();
    rst = 1'b0;
    expect_gnt(I_FIX, 4'b0100, "mid_fix_post");
    expect_gnt(I_RR4, 4'b0010, "mid_rr4_post");
    expect_gnt(I_ONE, 4'b0001, "mid_one_post");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
